// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - serial input and received-word bundle for uart_rx_cfg
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 uart_rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 new_data;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;

    // master is the receiver producing words; slave drives the line and consumes words
    modport master (
        input  uart_rx,
        output data_out, new_data, parity_err, frame_err, break_det
    );
    modport slave (
        output uart_rx,
        input  data_out, new_data, parity_err, frame_err, break_det
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with 3-sample majority voting and error flags
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_cfg_if.master rx_if
);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] MID      = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] MID_P1   = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    state_t               state, state_next;
    logic                 rx_meta, rx_s;
    logic [CW-1:0]        baud_cnt;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift_hold;
    logic                 s0, s1;
    logic                 perr, ferr_acc, any_high;
    logic                 maj, wrap, decide, last_stop, frame_done;

    assign maj       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign wrap      = (baud_cnt == LAST);
    assign decide    = (baud_cnt == MID_P1);
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_if.uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            IDLE:    if (!rx_s) state_next = START;
            START: begin
                if (decide && maj) state_next = IDLE;
                else if (wrap)     state_next = DATA;
            end
            DATA:    if (wrap && bit_idx == LAST_BIT) state_next = (PARITY != 0) ? PAR : STOP;
            PAR:     if (wrap) state_next = STOP;
            STOP: begin
                if (decide && last_stop) begin
                    frame_done = 1'b1;
                    state_next = maj ? IDLE : WAIT_HI;
                end
            end
            WAIT_HI: if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt          <= '0;
            bit_idx           <= '0;
            stop_idx          <= 1'b0;
            shift_hold        <= '0;
            s0                <= 1'b1;
            s1                <= 1'b1;
            perr              <= 1'b0;
            ferr_acc          <= 1'b0;
            any_high          <= 1'b0;
            rx_if.data_out    <= '0;
            rx_if.new_data    <= 1'b0;
            rx_if.parity_err  <= 1'b0;
            rx_if.frame_err   <= 1'b0;
            rx_if.break_det   <= 1'b0;
        end else begin
            rx_if.new_data <= 1'b0;
            if (baud_cnt == MID_M1) s0 <= rx_s;
            if (baud_cnt == MID)    s1 <= rx_s;

            // The IDLE cycle that sees the low line already counts as baud 0 of the start bit
            if (state_next == IDLE || state_next == WAIT_HI) baud_cnt <= '0;
            else if (state == IDLE)                          baud_cnt <= CW'(1);
            else if (wrap)                                   baud_cnt <= '0;
            else                                             baud_cnt <= baud_cnt + CW'(1);

            case (state)
                IDLE: begin
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    perr     <= 1'b0;
                    ferr_acc <= 1'b0;
                    any_high <= 1'b0;
                end
                DATA: begin
                    if (decide) begin
                        shift_hold[bit_idx] <= maj;
                        any_high            <= any_high | maj;
                    end
                    if (wrap) bit_idx <= bit_idx + IW'(1);
                end
                PAR: begin
                    if (decide) begin
                        perr     <= (PARITY == 2) ? (^shift_hold ^ maj) : ~(^shift_hold ^ maj);
                        any_high <= any_high | maj;
                    end
                end
                STOP: begin
                    if (decide) begin
                        ferr_acc <= ferr_acc | ~maj;
                        any_high <= any_high | maj;
                    end
                    if (wrap) stop_idx <= 1'b1;
                end
                default: ;
            endcase

            if (frame_done) begin
                rx_if.data_out   <= shift_hold;
                rx_if.new_data   <= 1'b1;
                rx_if.parity_err <= (PARITY != 0) & perr;
                rx_if.frame_err  <= ferr_acc | ~maj;
                rx_if.break_det  <= ~(any_high | maj);
            end
        end
    end
endmodule
